// File: rtl/mem_decoder_pkg.sv
// rtl/mem_decoder_pkg.sv - shared state encoding, error data default and region match helper for mem_decoder
package mem_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } mem_dec_state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

    function automatic logic region_hit(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/mem_region_match.sv
// rtl/mem_region_match.sv - combinational base/mask region decoder, lowest matching index wins
module mem_region_match
    import mem_decoder_pkg::*;
#(
    parameter int                   NSLAVES    = 4,
    parameter int                   SEL_W      = 2,
    parameter logic [NSLAVES*32-1:0] SLAVE_BASE = {NSLAVES{32'h0}},
    parameter logic [NSLAVES*32-1:0] SLAVE_MASK = {NSLAVES{32'h0}}
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [SEL_W-1:0] sel
);

    // Scan from the top down so the lowest-index match is the last one written.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (region_hit(addr, SLAVE_BASE[32*i +: 32], SLAVE_MASK[32*i +: 32])) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_decoder.sv
// rtl/mem_decoder.sv - registered memory-bus interconnect with decode-miss errors; optional slave timeout under MEM_DECODER_TIMEOUT_EN
module mem_decoder
    import mem_decoder_pkg::*;
#(
    parameter int                    NSLAVES        = 4,
    parameter logic [NSLAVES*32-1:0] SLAVE_BASE     = {NSLAVES{32'h0}},
    parameter logic [NSLAVES*32-1:0] SLAVE_MASK     = {NSLAVES{32'h0}},
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [31:0]           ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    m_valid,
    output logic                    m_ready,
    input  logic [31:0]             m_addr,
    input  logic [31:0]             m_wdata,
    input  logic [3:0]              m_wstrb,
    output logic [31:0]             m_rdata,
    output logic                    m_err,
    output logic [NSLAVES-1:0]      s_valid,
    input  logic [NSLAVES-1:0]      s_ready,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    output logic [3:0]              s_wstrb,
    input  logic [NSLAVES*32-1:0]   s_rdata,
    output logic [31:0]             err_addr,
    output logic [15:0]             err_count
);

    localparam int SEL_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_ACCESS = ST_ACCESS;
    localparam logic [1:0] S_RESP   = ST_RESP;
    localparam logic [1:0] S_ERR    = ST_ERR;

    logic [1:0]       state;
    logic [SEL_W-1:0] sel_q;
    logic [31:0]      rdata_q;
    logic             hit;
    logic [SEL_W-1:0] hit_sel;
    logic [31:0]      sel_rdata;
    logic             sel_ready;
    logic [15:0]      err_count_inc;

    mem_region_match #(
        .NSLAVES    (NSLAVES),
        .SEL_W      (SEL_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_match (
        .addr (m_addr),
        .hit  (hit),
        .sel  (hit_sel)
    );

    assign sel_rdata     = s_rdata[32*int'(sel_q) +: 32];
    assign sel_ready     = s_ready[sel_q];
    assign err_count_inc = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        s_valid = '0;
        if (state == S_ACCESS) begin
            s_valid[sel_q] = 1'b1;
        end
    end

    assign m_ready = (state == S_RESP) || (state == S_ERR);
    assign m_err   = (state == S_ERR);
    assign m_rdata = (state == S_ERR)  ? ERR_RDATA :
                     (state == S_RESP) ? rdata_q   : 32'h0;

`ifdef MEM_DECODER_TIMEOUT_EN
    logic [15:0] wait_cnt;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            sel_q     <= '0;
            rdata_q   <= 32'h0;
            s_addr    <= 32'h0;
            s_wdata   <= 32'h0;
            s_wstrb   <= 4'h0;
            err_addr  <= 32'h0;
            err_count <= 16'h0;
`ifdef MEM_DECODER_TIMEOUT_EN
            wait_cnt  <= 16'h0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (m_valid) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_wstrb <= m_wstrb;
                        if (hit) begin
                            sel_q <= hit_sel;
                            state <= S_ACCESS;
`ifdef MEM_DECODER_TIMEOUT_EN
                            wait_cnt <= 16'h0;
`endif
                        end else begin
                            err_addr  <= m_addr;
                            err_count <= err_count_inc;
                            state     <= S_ERR;
                        end
                    end
                end
                S_ACCESS: begin
                    // A master that gives up mid-access gets no response and no error.
                    if (!m_valid) begin
                        state <= S_IDLE;
                    end else if (sel_ready) begin
                        rdata_q <= sel_rdata;
                        state   <= S_RESP;
                    end
`ifdef MEM_DECODER_TIMEOUT_EN
                    else if (wait_cnt == 16'(TIMEOUT_CYCLES)) begin
                        err_addr  <= s_addr;
                        err_count <= err_count_inc;
                        state     <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                S_RESP:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_decoder.sv
// tb/tb_mem_decoder.sv - randomized self-checking bench for mem_decoder against a transaction-level model
module tb_mem_decoder;

    localparam int NS = 4;
    localparam int TO = 8;
    localparam logic [NS*32-1:0] BASE = {32'h0300_1000, 32'h0300_0000, 32'h0200_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASK = {32'hFFFF_F000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           m_valid = 1'b0;
    logic           m_ready;
    logic [31:0]    m_addr = 32'h0;
    logic [31:0]    m_wdata = 32'h0;
    logic [3:0]     m_wstrb = 4'h0;
    logic [31:0]    m_rdata;
    logic           m_err;
    logic [NS-1:0]  s_valid;
    logic [NS-1:0]  s_ready = '0;
    logic [31:0]    s_addr;
    logic [31:0]    s_wdata;
    logic [3:0]     s_wstrb;
    logic [NS*32-1:0] s_rdata = '0;
    logic [31:0]    err_addr;
    logic [15:0]    err_count;

    mem_decoder #(
        .NSLAVES        (NS),
        .SLAVE_BASE     (BASE),
        .SLAVE_MASK     (MASK),
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_rdata   (m_rdata),
        .m_err     (m_err),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_rdata   (s_rdata),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    logic [31:0] reg_base [NS];
    logic [31:0] reg_mask [NS];

    logic          exp_m_ready, exp_m_err, exp_req;
    logic [NS-1:0] exp_s_valid;
    logic [31:0]   exp_rdata, exp_addr, exp_wdata;
    logic [3:0]    exp_wstrb;
    logic [31:0]   mdl_err_addr = 32'h0;
    logic [15:0]   mdl_err_count = 16'h0;

    int            last_resp_cyc;
    logic [31:0]   last_rdata;
    logic          last_err;
    logic [NS-1:0] seen_sv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & reg_mask[i]) == reg_base[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ready", 32'(m_ready), 32'(exp_m_ready));
            chk("m_err", 32'(m_err), 32'(exp_m_err));
            chk("s_valid", 32'(s_valid), 32'(exp_s_valid));
            if (exp_m_ready) chk("m_rdata", m_rdata, exp_rdata);
            if (exp_req) begin
                chk("s_addr", s_addr, exp_addr);
                chk("s_wdata", s_wdata, exp_wdata);
                chk("s_wstrb", 32'(s_wstrb), 32'(exp_wstrb));
            end
            chk("err_addr", err_addr, mdl_err_addr);
            chk("err_count", 32'(err_count), 32'(mdl_err_count));
            if (m_ready) begin
                last_resp_cyc = cyc;
                last_rdata    = m_rdata;
                last_err      = m_err;
            end
            seen_sv = seen_sv | s_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_idle_exp();
        exp_m_ready = 1'b0;
        exp_m_err   = 1'b0;
        exp_s_valid = '0;
        exp_req     = 1'b0;
        exp_rdata   = 32'h0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            m_valid = 1'b0;
            s_ready = NS'($urandom);
            set_idle_exp();
        end
    endtask

    // wt: slave wait states (-1 = slave never ready); drop_at: cycle in which the master abandons (0 = never)
    task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input logic [31:0] data, input int wt, input int drop_at);
        int sl;
        int resp;
        logic [NS-1:0] oh;
        step();
        cyc = 0;
        last_resp_cyc = -1;
        seen_sv = '0;
        sl = model_decode(a);
        for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = $urandom;
        if (sl >= 0) s_rdata[32*sl +: 32] = data;
        oh = (sl >= 0) ? (NS'(1) << sl) : '0;
        m_valid = 1'b1;
        m_addr  = a;
        m_wdata = wd;
        m_wstrb = ws;
        s_ready = NS'($urandom);
        set_idle_exp();
        if (sl < 0)       resp = 1;
        else if (wt >= 0) resp = 2 + wt;
`ifdef MEM_DECODER_TIMEOUT_EN
        else              resp = TO + 2;
`else
        else              resp = -1;
`endif
        if (drop_at != 0) resp = -1;
        while (cyc < 3000) begin
            step();
            if (drop_at != 0 && cyc == drop_at) m_valid = 1'b0;
            exp_req   = 1'b1;
            exp_addr  = a;
            exp_wdata = wd;
            exp_wstrb = ws;
            exp_m_ready = (cyc == resp);
            if (sl < 0) begin
                exp_s_valid = '0;
                exp_m_err   = (cyc == 1);
                exp_rdata   = 32'hDEADBEEF;
                s_ready     = NS'($urandom);
                if (cyc == 1) begin
                    mdl_err_addr  = a;
                    mdl_err_count = (mdl_err_count == 16'hFFFF) ? 16'hFFFF : mdl_err_count + 16'd1;
                end
            end else begin
                exp_s_valid = (cyc >= 1 && (resp < 0 || cyc < resp) && (drop_at == 0 || cyc <= drop_at)) ? oh : '0;
                exp_m_err   = (cyc == resp) && (wt < 0);
                exp_rdata   = (wt < 0) ? 32'hDEADBEEF : data;
                if (wt >= 0 && cyc == 1 + wt) s_ready = NS'($urandom) | oh;
                else                          s_ready = NS'($urandom) & ~oh;
                if (wt < 0 && cyc == resp) begin
                    mdl_err_addr  = a;
                    mdl_err_count = (mdl_err_count == 16'hFFFF) ? 16'hFFFF : mdl_err_count + 16'd1;
                end
            end
            if (resp > 0 && cyc == resp) break;
            if (drop_at != 0 && cyc == drop_at + 2) break;
        end
        if (cyc >= 3000) chk("txn_bound", 32'(cyc), 32'(resp));
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [7:0] miss_tops [4];
        miss_tops[0] = 8'h04; miss_tops[1] = 8'h10; miss_tops[2] = 8'h80; miss_tops[3] = 8'hFF;
        case ($urandom_range(0, 4))
            0: return {8'h00, 24'($urandom)};
            1: return {8'h02, 24'($urandom)};
            2: return {8'h03, 24'($urandom)};
            3: return {20'h03001, 12'($urandom)};
            default: return {miss_tops[$urandom_range(0, 3)], 24'($urandom)};
        endcase
    endfunction

    initial begin
        reg_base[0] = 32'h0000_0000; reg_mask[0] = 32'hFF00_0000;
        reg_base[1] = 32'h0200_0000; reg_mask[1] = 32'hFF00_0000;
        reg_base[2] = 32'h0300_0000; reg_mask[2] = 32'hFF00_0000;
        reg_base[3] = 32'h0300_1000; reg_mask[3] = 32'hFFFF_F000;
        set_idle_exp();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_ready", 32'(m_ready), 32'h0);
        chk("rst_s_valid", 32'(s_valid), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        resetn = 1'b1;
        chk_en = 1'b1;
        idle(2);

        run_txn(32'h0500_0000, 32'h0, 4'h0, 32'h0, 0, 0);
        chk("miss_resp_cyc", 32'(last_resp_cyc), 32'd1);
        chk("miss_rdata", last_rdata, 32'hDEADBEEF);
        chk("miss_err", 32'(last_err), 32'h1);
        chk("miss_err_addr", err_addr, 32'h0500_0000);
        chk("miss_err_count", 32'(err_count), 32'd1);

        run_txn(32'h0200_0010, 32'h0, 4'h0, 32'h1234_5678, 0, 0);
        chk("rd_resp_cyc", 32'(last_resp_cyc), 32'd2);
        chk("rd_rdata", last_rdata, 32'h1234_5678);
        chk("rd_err", 32'(last_err), 32'h0);
        chk("rd_sel", 32'(seen_sv), 32'h2);

        run_txn(32'h0300_1234, 32'h0, 4'h0, 32'hCAFE_0002, 1, 0);
        chk("overlap_sel", 32'(seen_sv), 32'h4);

        run_txn(32'h0000_0100, 32'hA5A5_5A5A, 4'b0011, 32'h0BAD_F00D, 3, 0);
        chk("wr_resp_cyc", 32'(last_resp_cyc), 32'd5);
        chk("wr_rdata", last_rdata, 32'h0BAD_F00D);
        idle(1);

`ifdef MEM_DECODER_TIMEOUT_EN
        run_txn(32'h0200_0400, 32'h0, 4'h0, 32'h0, -1, 0);
        chk("to_resp_cyc", 32'(last_resp_cyc), 32'd10);
        chk("to_err", 32'(last_err), 32'h1);
        chk("to_err_addr", err_addr, 32'h0200_0400);
`else
        run_txn(32'h0200_0400, 32'h0, 4'h0, 32'h0, -1, 1001);
        chk("pending_no_resp", 32'(last_resp_cyc), 32'hFFFF_FFFF);
`endif
        run_txn(32'h0000_0040, 32'h0, 4'h0, 32'h0, -1, 3);
        chk("abandon_no_resp", 32'(last_resp_cyc), 32'hFFFF_FFFF);

        for (int n = 0; n < 80; n++) begin
            run_txn(rand_addr(), $urandom, 4'($urandom), $urandom, $urandom_range(0, 4), 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        idle(1);
        force dut.err_count = 16'hFFFD;
        #1;
        release dut.err_count;
        mdl_err_count = 16'hFFFD;
        for (int n = 0; n < 3; n++) run_txn(32'h0400_0000 + 32'(n), 32'h0, 4'h0, 32'h0, 0, 0);
        chk("sat_err_count", 32'(err_count), 32'h0000_FFFF);
        idle(1);

        chk_en = 1'b0;
        step();
        m_valid = 1'b1;
        m_addr  = 32'h0200_0040;
        s_ready = '0;
        step();
        chk("rst_mid_pre_svalid", 32'(s_valid), 32'h2);
        resetn = 1'b0;
        #1;
        chk("rst_mid_svalid", 32'(s_valid), 32'h0);
        chk("rst_mid_m_ready", 32'(m_ready), 32'h0);
        chk("rst_mid_err_count", 32'(err_count), 32'h0);
        m_valid = 1'b0;
        step();
        resetn = 1'b1;
        mdl_err_count = 16'h0;
        mdl_err_addr  = 32'h0;
        set_idle_exp();
        @(negedge clk);
        #1;
        chk_en = 1'b1;
        run_txn(32'h0300_0008, 32'h0, 4'h0, 32'h7777_0003, 0, 0);
        chk("post_rst_resp_cyc", 32'(last_resp_cyc), 32'd2);
        chk("post_rst_rdata", last_rdata, 32'h7777_0003);
        idle(2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_decoder.md
# mem_decoder

Parametrised, registered memory-bus interconnect. It routes one `valid/ready` master (the core's memory port) to `NSLAVES` slave ports, each selected by a base/mask address region. Unlike a purely combinational address decoder, it latches the selected slave per transaction and registers the response. It also answers unmapped addresses with a bus error and can abort hung slaves on a timeout. It sits between `core` and the RAM, SPI-flash, config-register and IO slaves in the SoC top.

## Interface
- `NSLAVES`, 4: number of slave ports, range 1..16.
- `SLAVE_BASE`, {NSLAVES{32'h0}}: packed `NSLAVES*32` vector; slice i is the base address of slave i.
- `SLAVE_MASK`, {NSLAVES{32'h0}}: packed `NSLAVES*32` vector; slave i hits when `(m_addr & MASK_i) == BASE_i`.
- `TIMEOUT_CYCLES`, 255: maximum number of ACCESS cycles before the abort; range 1..65535.
- `ERR_RDATA`, 32'hDEADBEEF: value of `m_rdata` on any error response.

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: reset, asynchronous and active-low.
- `m_valid` in 1: master request.
- `m_ready` out 1: one-cycle response pulse.
- `m_addr` in 32, `m_wdata` in 32, `m_wstrb` in 4: request fields; `wstrb==0` means a read.
- `m_rdata` out 32: response data, valid while `m_ready` is high.
- `m_err` out 1: the response is an error (decode miss or timeout).
- `s_valid` out NSLAVES: one-hot request to the selected slave.
- `s_ready` in NSLAVES: per-slave ready.
- `s_addr` out 32, `s_wdata` out 32, `s_wstrb` out 4: latched request, shared by all slaves.
- `s_rdata` in NSLAVES*32: packed read data; slice i belongs to slave i.
- `err_addr` out 32: address of the most recent error.
- `err_count` out 16: number of error responses, saturating.

## Operation
- State machine states: IDLE, ACCESS, RESP, ERR.
- IDLE behaviour:
  - On `m_valid`, latch addr/wdata/wstrb and the decode result.
  - On a hit, go to ACCESS with `sel` = lowest-index matching slave; overlapping regions resolve by priority.
  - On a miss, go to ERR.
- ACCESS behaviour:
  - Hold `s_valid[sel]=1`.
  - When `s_ready[sel]` is high, capture `s_rdata[sel]` and go to RESP with err=0.
  - `s_ready` bits of unselected slaves are ignored.
- RESP: drive `m_ready=1` and `m_rdata` from the capture register, then go to IDLE.
- ERR: drive `m_ready=1`, `m_err=1`, `m_rdata=ERR_RDATA`, then go to IDLE.
- Error bookkeeping: every error response updates `err_addr` and increments `err_count`; the count holds at 16'hFFFF.
- Master protocol: the master holds `m_valid` and all fields stable until `m_ready`, then deasserts `m_valid` on the following edge.
- `m_valid` falling during ACCESS is a protocol violation. The block drops `s_valid` and returns to IDLE with no response and no error count.
- Writes: `m_rdata` carries the slave's `s_rdata` unchanged; the block applies no write-specific masking.
- Reset values, applied asynchronously: state IDLE; all outputs 0, including `s_valid`, `m_ready`, `m_err`, `err_addr` and `err_count`. A reset during ACCESS drops `s_valid` immediately.

## Timing
- Request/response sequence, with `m_valid` first high at cycle 0:
  - `s_valid` is high from cycle 1.
  - A zero-wait slave returns `s_ready` in cycle 1.
  - `m_ready` is high in cycle 2.
- Minimum latency is therefore 2 cycles; each slave wait state adds 1 cycle.
- Decode miss: `m_ready` and `m_err` are high in cycle 1.
- `s_valid` is never high in the same cycle as `m_ready`.
- Back-to-back: a new `m_valid` seen in IDLE at cycle 3 starts the next transaction.

## Configuration
- Macro: `MEM_DECODER_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle.
  - If the count reaches `TIMEOUT_CYCLES` with `s_ready[sel]` low, `s_valid` drops and the FSM goes to ERR.
  - Abort timing: with `TIMEOUT_CYCLES=N`, `m_err` is high in cycle N+2.
  - If `s_ready` arrives in the same cycle as the terminal count, `s_ready` wins and the response is normal.
- Not defined: no counter; ACCESS waits indefinitely; `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `mem_decoder_pkg` contains:
  - the state enum `mem_dec_state_t`;
  - the `ERR_RDATA` default constant;
  - the function `region_hit(addr, base, mask)`.
- Sub-module `mem_region_match`: combinational priority encoder producing `hit` and a `$clog2(NSLAVES)`-bit `sel` from `m_addr`, `SLAVE_BASE` and `SLAVE_MASK`.
- The FSM, latches and timeout counter live in `mem_decoder`.

## Test plan
1. Read hit, zero-wait slave: NSLAVES=4, slave 1 base 32'h02000000 mask 32'hFF000000, read 32'h02000010 with `s_rdata[1]`=32'h12345678 -> `s_valid[1]` high in cycle 1 only, `m_ready` in cycle 2, `m_rdata`=32'h12345678, `m_err`=0.
2. Overlap priority: slave 0 mask 0 (match-all) and slave 2 matching -> slave 0 selected, `s_valid[2]` never high.
3. Unmapped address, with no match-all slave: address 32'h05000000 -> `m_ready`+`m_err` in cycle 1, `m_rdata`=32'hDEADBEEF, `err_addr`=32'h05000000, `err_count`=1; 65536 misses leave `err_count`=16'hFFFF.
4. Timeout, macro defined, TIMEOUT_CYCLES=8, `s_ready` stuck low -> `s_valid` drops and `m_err` is high in cycle 10; with the macro undefined, the access is still pending after 1000 cycles.
5. Write with 3 wait states, `m_wstrb`=4'b0011 -> `s_wstrb`=4'b0011 and `s_wdata` equal to `m_wdata` throughout; `m_ready` in cycle 5.
6. `resetn` low during ACCESS -> `s_valid`, `m_ready` and `err_count` are 0 before the next clock edge; state IDLE after release.
